// File: rtl/tick_timer_pkg.sv
// Shared definitions for the microsecond tick timer.
// Holds the register byte offsets within the 6-word window, the ID constant,
// the CTRL bit positions and the countdown FSM state encoding.
package tick_timer_pkg;

    // Identification word: ASCII "TIMR".
    localparam logic [31:0] ID_VALUE = 32'h5449_4D52;

    // Size of the register window in bytes (6 words).
    localparam logic [31:0] WINDOW_BYTES = 32'd24;

    // Register byte offsets relative to ADDR_BASE.
    localparam logic [4:0] OFF_ID     = 5'h00;
    localparam logic [4:0] OFF_CTRL   = 5'h04;
    localparam logic [4:0] OFF_PERIOD = 5'h08;
    localparam logic [4:0] OFF_COUNT  = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;
    localparam logic [4:0] OFF_MISSED = 5'h14;

    // CTRL bit positions.
    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_PERIODIC_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

    // Countdown FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_timer_core.sv
// Countdown engine of the tick timer: FSM, COUNT and MISSED counters.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   tick_i           one-clk microsecond pulse
//   start_i          CTRL write with enable=1 (start or restart)
//   stop_i           CTRL write with enable=0
//   periodic_i       CTRL.periodic
//   period_i         current PERIOD register
//   clear_missed_i   STATUS write-1 to the pending bit
//   pending_i        current STATUS.pending
//   count_o          COUNT register
//   missed_o         MISSED counter (saturating)
//   state_o          FSM state
//   expire_o         one-clk pulse when the countdown reaches its end
module tick_timer_core
    import tick_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        periodic_i,
    input  logic [31:0] period_i,
    input  logic        clear_missed_i,
    input  logic        pending_i,
    output logic [31:0] count_o,
    output logic [15:0] missed_o,
    output state_e      state_o,
    output logic        expire_o
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [15:0] missed_q, missed_d;
    logic        expire;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        if (start_i) begin
            // A bus command takes precedence over a coincident tick.
            if (period_i != 32'd0) begin
                state_d = ST_RUN;
                count_d = period_i;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (stop_i) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN && tick_i) begin
            if (count_q == 32'd1) begin
                expire = 1'b1;
                // A PERIOD of zero written while running cannot be reloaded,
                // so it ends the countdown like a one-shot.
                if (periodic_i && period_i != 32'd0) begin
                    count_d = period_i;
                end else begin
                    count_d = 32'd0;
                    state_d = ST_DONE;
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end
    end

    // Clearing wins over counting so that a clear coinciding with a missed
    // expiry still leaves MISSED at zero.
    always_comb begin
        missed_d = missed_q;
        if (clear_missed_i) begin
            missed_d = 16'd0;
        end else if (expire && pending_i && missed_q != 16'hFFFF) begin
            missed_d = missed_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 32'd0;
            missed_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            missed_q <= missed_d;
        end
    end

    assign count_o  = count_q;
    assign missed_o = missed_q;
    assign state_o  = state_q;
    assign expire_o = expire;

endmodule

// File: rtl/tick_timer.sv
// Memory-mapped microsecond tick timer with a 6-word register window.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   tick_us     one-clk pulse per elapsed microsecond
//   mem_valid   bus request strobe
//   mem_ready   one-clk acknowledge for in-window requests
//   mem_addr    byte address (word aligned)
//   mem_wdata   write data
//   mem_wstrb   byte enables; zero means read, only 4'b1111 writes
//   mem_rdata   read data, valid while mem_ready is high
//   irq         registered STATUS.pending AND CTRL.irq_en
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_us,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    logic        ready_q, busy_q, busy_d;
    logic [31:0] rdata_q, rdata_d;
    logic        periodic_q, irq_en_q, pending_q, pending_d, irq_q;
    logic [31:0] period_q;

    logic [31:0] offset;
    logic [4:0]  word_sel;
    logic        accept, wr_en, ctrl_wr, start, stop, status_clr;

    logic [31:0] core_count;
    logic [15:0] core_missed;
    state_e      core_state;
    logic        core_expire;

    // Addresses below the base wrap to a large offset and fall out of window.
    assign offset   = mem_addr - ADDR_BASE;
    assign word_sel = {offset[4:2], 2'b00};

    // busy_q stays set while the acknowledged request is still held, so a
    // long mem_valid is answered once until it drops and rises again.
    assign accept     = mem_valid && (offset < WINDOW_BYTES) && !busy_q;
    assign busy_d     = mem_valid && (busy_q || accept);
    assign wr_en      = accept && (mem_wstrb == 4'b1111);
    assign ctrl_wr    = wr_en && (word_sel == OFF_CTRL);
    assign start      = ctrl_wr && mem_wdata[CTRL_ENABLE_BIT];
    assign stop       = ctrl_wr && !mem_wdata[CTRL_ENABLE_BIT];
    assign status_clr = wr_en && (word_sel == OFF_STATUS) && mem_wdata[0];

    // Expiry sets pending even when a clear lands in the same clk.
    always_comb begin
        pending_d = pending_q;
        if (core_expire) begin
            pending_d = 1'b1;
        end else if (status_clr) begin
            pending_d = 1'b0;
        end
    end

    // CTRL.enable is not stored: it reads back as "the FSM is running".
    always_comb begin
        rdata_d = 32'd0;
        if (accept) begin
            case (word_sel)
                OFF_ID:     rdata_d = ID_VALUE;
                OFF_CTRL: begin
                    rdata_d[CTRL_ENABLE_BIT]   = (core_state == ST_RUN);
                    rdata_d[CTRL_PERIODIC_BIT] = periodic_q;
                    rdata_d[CTRL_IRQ_EN_BIT]   = irq_en_q;
                end
                OFF_PERIOD: rdata_d = period_q;
                OFF_COUNT:  rdata_d = core_count;
                OFF_STATUS: rdata_d = {31'd0, pending_q};
                OFF_MISSED: rdata_d = {16'd0, core_missed};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= 32'd0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= 32'd0;
            pending_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ready_q   <= accept;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
            pending_q <= pending_d;
            irq_q     <= pending_q && irq_en_q;
            if (ctrl_wr) begin
                periodic_q <= mem_wdata[CTRL_PERIODIC_BIT];
                irq_en_q   <= mem_wdata[CTRL_IRQ_EN_BIT];
            end
            if (wr_en && word_sel == OFF_PERIOD) begin
                period_q <= mem_wdata;
            end
        end
    end

    tick_timer_core u_core (
        .clk            (clk),
        .rst            (rst),
        .tick_i         (tick_us),
        .start_i        (start),
        .stop_i         (stop),
        .periodic_i     (periodic_q),
        .period_i       (period_q),
        .clear_missed_i (status_clr),
        .pending_i      (pending_q),
        .count_o        (core_count),
        .missed_o       (core_missed),
        .state_o        (core_state),
        .expire_o       (core_expire)
    );

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer. Read expectations are queued
// when a read is issued and compared when the DUT acknowledges it.
module tb_tick_timer;
    import tick_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_us;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        irq;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    tick_timer #(.ADDR_BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_us   (tick_us),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; optionally raises tick_us in the accept clk.
    task automatic bus_xfer(input logic [31:0] off, input logic [31:0] wdata,
                            input logic [3:0] strb, input bit with_tick,
                            output logic [31:0] rdata, output bit ok);
        ok        = 1'b0;
        rdata     = 32'd0;
        mem_valid = 1'b1;
        mem_addr  = BASE + off;
        mem_wdata = wdata;
        mem_wstrb = strb;
        tick_us   = with_tick;
        for (int i = 0; i < 16; i++) begin
            step();
            tick_us = 1'b0;
            if (mem_ready) begin
                ok    = 1'b1;
                rdata = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        step();
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data,
                      input logic [3:0] strb = 4'hF, input bit with_tick = 1'b0);
        logic [31:0] rd_unused;
        bit ok;
        bus_xfer(off, data, strb, with_tick, rd_unused, ok);
        check($sformatf("wr_ack_%0h", off), {31'd0, ok}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] data;
        bit ok;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_xfer(off, 32'd0, 4'd0, 1'b0, data, ok);
        if (ok) begin
            check(tag_q.pop_front(), data, exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
            check({tag_q.pop_front(), "_timeout"}, {31'd0, ok}, 32'd1);
        end
    endtask

    task automatic tick_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick_us = 1'b1;
            step();
            tick_us = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    initial begin
        int acks;
        logic [31:0] held_data;

        rst       = 1'b1;
        tick_us   = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        #2;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Reset values through the bus.
        rd(OFF_ID, ID_VALUE, "id");
        rd(OFF_CTRL, 32'd0, "rst_ctrl");
        rd(OFF_PERIOD, 32'd0, "rst_period");
        rd(OFF_COUNT, 32'd0, "rst_count");
        rd(OFF_STATUS, 32'd0, "rst_status");
        rd(OFF_MISSED, 32'd0, "rst_missed");

        // Out-of-window requests get no acknowledge.
        acks = 0;
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h18;
        repeat (5) begin step(); if (mem_ready) acks++; end
        mem_addr  = BASE - 32'h4;
        repeat (5) begin step(); if (mem_ready) acks++; end
        mem_valid = 1'b0;
        step();
        check("oow_acks", acks, 32'd0);

        // Periodic with irq: PERIOD=3, ticks every 10 clk.
        wr(OFF_PERIOD, 32'd3);
        wr(OFF_CTRL, 32'h7);
        rd(OFF_COUNT, 32'd3, "p3_count_start");
        tick_n(3, 10);
        check("p3_irq1", {31'd0, irq}, 32'd1);
        rd(OFF_STATUS, 32'd1, "p3_pending");
        rd(OFF_COUNT, 32'd3, "p3_reload");
        rd(OFF_MISSED, 32'd0, "p3_missed0");
        tick_n(3, 10);
        check("p3_irq2", {31'd0, irq}, 32'd1);
        rd(OFF_MISSED, 32'd1, "p3_missed1");
        wr(OFF_STATUS, 32'd1, 4'b0001);
        rd(OFF_STATUS, 32'd1, "partial_wr_ignored");
        wr(OFF_STATUS, 32'd1);
        rd(OFF_STATUS, 32'd0, "status_cleared");
        rd(OFF_MISSED, 32'd0, "missed_cleared");
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wr(OFF_COUNT, 32'h55);
        rd(OFF_COUNT, 32'd3, "count_ro");

        // One-shot with irq: PERIOD=5.
        wr(OFF_CTRL, 32'd0);
        wr(OFF_PERIOD, 32'd5);
        wr(OFF_CTRL, 32'h5);
        tick_n(4, 10);
        tick_us = 1'b1;
        step();
        tick_us = 1'b0;
        check("irq_latency_pre", {31'd0, irq}, 32'd0);
        step();
        check("irq_latency_post", {31'd0, irq}, 32'd1);
        check("os_state_done", 32'(dut.core_state), 32'(ST_DONE));
        rd(OFF_COUNT, 32'd0, "os_count");
        rd(OFF_CTRL, 32'h4, "os_ctrl");
        tick_n(10, 3);
        rd(OFF_COUNT, 32'd0, "os_count_after");
        wr(OFF_STATUS, 32'd1);

        // Enable with PERIOD=0 stays idle.
        wr(OFF_CTRL, 32'd0);
        wr(OFF_PERIOD, 32'd0);
        wr(OFF_CTRL, 32'h1);
        check("p0_state", 32'(dut.core_state), 32'(ST_IDLE));
        rd(OFF_CTRL, 32'd0, "p0_ctrl");
        tick_n(4, 3);
        rd(OFF_COUNT, 32'd0, "p0_count");
        check("p0_irq", {31'd0, irq}, 32'd0);

        // Expiry and STATUS clear in the same clk, with pending already set.
        wr(OFF_PERIOD, 32'd2);
        wr(OFF_CTRL, 32'h3);
        tick_n(2, 3);
        rd(OFF_STATUS, 32'd1, "p2_pending");
        tick_n(1, 3);
        wr(OFF_STATUS, 32'd1, 4'hF, 1'b1);
        rd(OFF_STATUS, 32'd1, "coinc_pending");
        rd(OFF_MISSED, 32'd0, "coinc_missed");
        rd(OFF_COUNT, 32'd2, "coinc_reload");

        // PERIOD change while running takes effect on reload.
        wr(OFF_CTRL, 32'd0);
        wr(OFF_PERIOD, 32'd100);
        wr(OFF_CTRL, 32'h3);
        tick_n(60, 2);
        rd(OFF_COUNT, 32'd40, "p100_count40");
        wr(OFF_PERIOD, 32'd7);
        rd(OFF_COUNT, 32'd40, "p100_count_kept");
        tick_n(39, 2);
        rd(OFF_COUNT, 32'd1, "p100_count1");
        tick_n(1, 2);
        rd(OFF_COUNT, 32'd7, "p7_reload");

        // Restart with a coincident tick, then stop holds COUNT.
        tick_n(1, 2);
        rd(OFF_COUNT, 32'd6, "pre_restart");
        wr(OFF_CTRL, 32'h3, 4'hF, 1'b1);
        rd(OFF_COUNT, 32'd7, "restart_count");
        tick_n(2, 2);
        wr(OFF_CTRL, 32'd0);
        check("stop_state", 32'(dut.core_state), 32'(ST_IDLE));
        tick_n(3, 2);
        rd(OFF_COUNT, 32'd5, "stop_count_held");

        // Asynchronous reset mid-run with a read in flight.
        wr(OFF_PERIOD, 32'd100);
        wr(OFF_CTRL, 32'h7);
        tick_n(50, 2);
        rd(OFF_COUNT, 32'd50, "pre_rst_count");
        rd(OFF_STATUS, 32'd1, "pre_rst_pending");
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        mem_valid = 1'b1;
        mem_addr  = BASE + OFF_ID;
        mem_wstrb = 4'd0;
        step();
        check("inflight_ready", {31'd0, mem_ready}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_ready", {31'd0, mem_ready}, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_rdata", mem_rdata, 32'd0);
        repeat (2) @(posedge clk);
        exp_q.push_back(ID_VALUE);
        tag_q.push_back("held_req_data");
        #3 rst = 1'b0;
        acks = 0;
        held_data = 32'd0;
        repeat (6) begin
            step();
            if (mem_ready) begin
                acks++;
                held_data = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        step();
        check("held_req_acks", acks, 32'd1);
        check(tag_q.pop_front(), held_data, exp_q.pop_front());
        rd(OFF_CTRL, 32'd0, "post_rst_ctrl");
        rd(OFF_PERIOD, 32'd0, "post_rst_period");
        rd(OFF_COUNT, 32'd0, "post_rst_count");
        rd(OFF_STATUS, 32'd0, "post_rst_status");
        rd(OFF_MISSED, 32'd0, "post_rst_missed");
        check("post_rst_state", 32'(dut.core_state), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 0, byte base address of the 6-word register window.
REQ-002 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tick_us  input  1  one-clk pulse per elapsed microsecond, driven by the clock block's microsecond divider.
REQ-005 SHALL have port mem_valid  input  1  bus request strobe.
REQ-006 SHALL have port mem_ready  output  1  one-clk acknowledge for a request addressed to this window.
REQ-007 SHALL have port mem_addr  input  32  byte address; word-aligned.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte write enables; all zero means read.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid while mem_ready is high.
REQ-011 SHALL have port irq  output  1  level interrupt = STATUS.pending AND CTRL.irq_en, registered.

Function
REQ-012 SHALL use registers: +0x00 ID (read 0x54494D52), +0x04 CTRL [0]=enable [1]=periodic [2]=irq_en, +0x08 PERIOD (32-bit, microseconds), +0x0C COUNT (read-only), +0x10 STATUS [0]=pending (write-1-to-clear), +0x14 MISSED (read-only, 16-bit, zero-extended).
REQ-013 SHALL assert mem_ready exactly one clk after a mem_valid for an in-window address, for one clk, then drop until the next mem_valid edge; no response to out-of-window addresses.
REQ-014 SHALL return 0 on reads of unmapped in-window words and ignore writes to them and to read-only registers.
REQ-015 SHALL perform writes only for wstrb==4'b1111; partial writes are ignored but still acknowledged.
REQ-016 SHALL implement FSM IDLE, RUN, DONE.
REQ-017 IDLE->RUN on a CTRL write setting enable with PERIOD!=0; COUNT loads PERIOD in that clk.
REQ-018 A CTRL write setting enable with PERIOD==0 SHALL leave the FSM in IDLE and enable reading back 0.
REQ-019 In RUN, each tick_us SHALL decrement COUNT by 1; ticks while IDLE or DONE are ignored.
REQ-020 On tick_us with COUNT==1 (expiry) SHALL set pending; periodic=1: COUNT reloads current PERIOD, stay RUN; periodic=0: COUNT=0, go DONE, enable clears.
REQ-021 Expiry while pending already set SHALL increment MISSED, saturating at 0xFFFF; MISSED clears on STATUS write-1.
REQ-022 PERIOD writes while RUN SHALL not alter COUNT; they take effect at the next reload or start.
REQ-023 CTRL write clearing enable SHALL go to IDLE from RUN or DONE; COUNT holds its value.
REQ-024 Expiry and STATUS clear in the same clk: expiry wins, pending remains 1, MISSED not incremented, MISSED cleared.
REQ-025 CTRL write with enable=1 while already RUN SHALL restart: COUNT reloads PERIOD; a coincident tick_us is discarded.
REQ-026 irq SHALL follow pending/irq_en changes with exactly one clk latency.

Reset
REQ-027 On rst high, without waiting for clk: FSM=IDLE, CTRL=0, PERIOD=0, COUNT=0, pending=0, MISSED=0, irq=0, mem_ready=0, mem_rdata=0.
REQ-028 rst mid-transaction SHALL drop mem_ready; a request held across rst release SHALL be acknowledged once, as new.

Structure
REQ-029 Register offsets, ID constant, CTRL bit indices and the FSM state encoding SHALL live in shared package tick_timer_pkg.
REQ-030 Countdown FSM, COUNT and MISSED SHALL be sub-module tick_timer_core; bus decode and CTRL/PERIOD/STATUS storage stay in tick_timer.

Verification
REQ-031 PERIOD=3, CTRL=0b111, ticks every 10 clk -> pending and irq after 3rd tick, COUNT reads 3 after reload; 2nd irq after 6th tick with MISSED=1.
REQ-032 PERIOD=5, CTRL=0b101 (one-shot) -> after 5 ticks FSM DONE, COUNT=0, CTRL reads 0b100, further 10 ticks leave COUNT 0.
REQ-033 PERIOD=0, CTRL=0b001 -> FSM IDLE, CTRL reads 0, 4 ticks leave COUNT 0, no irq.
REQ-034 PERIOD=2 periodic, STATUS write 1 in the expiry clk -> pending reads 1, MISSED reads 0.
REQ-035 PERIOD=100 running, PERIOD write 7 at COUNT=40 -> COUNT continues 39..1, reloads to 7.
REQ-036 rst pulsed asynchronously mid-RUN with COUNT=50 and pending=1 -> all registers read reset values; irq low before next clk edge.
